// File: rtl/sd_arb_pkg.sv
// Shared types for the SD card arbiter: controller state encodings, arbiter FSM
// states and the per-port request bundle.
package sd_arb_pkg;
  localparam int SECTOR_BITS = 4096;

  localparam logic [3:0] SD_INIT      = 4'd1;
  localparam logic [3:0] SD_IDLE      = 4'd2;
  localparam logic [3:0] SD_ERROR     = 4'd3;
  localparam logic [3:0] SD_TO_READ   = 4'd4;
  localparam logic [3:0] SD_READ_END  = 4'd5;
  localparam logic [3:0] SD_TO_WRITE  = 4'd6;
  localparam logic [3:0] SD_WRITE_END = 4'd7;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_RELEASE, S_ERROR
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [31:0]            addr;
    logic [SECTOR_BITS-1:0] wdata;
  } sd_req_t;
endpackage

// File: rtl/sd_arbiter_if.sv
// Requester and SD-controller bundle for sd_arbiter; slave = arbiter side,
// master = requesters plus controller.
interface sd_arbiter_if;
  import sd_arb_pkg::*;

  logic [1:0]             req;
  logic                   we0, we1;
  logic [31:0]            addr0, addr1;
  logic [SECTOR_BITS-1:0] wdata0, wdata1;
  logic [1:0]             done;
  logic                   err;
  logic                   busy;
  logic [SECTOR_BITS-1:0] rdata;
  logic                   sd_ctrl_re, sd_ctrl_we;
  logic [31:0]            sd_ctrl_addr_read, sd_ctrl_addr_write;
  logic [SECTOR_BITS-1:0] sd_ctrl_data_write, sd_ctrl_data_read;
  logic [3:0]             sd_state;

  modport slave (
    input  req, we0, we1, addr0, addr1, wdata0, wdata1, sd_ctrl_data_read, sd_state,
    output done, err, busy, rdata, sd_ctrl_re, sd_ctrl_we,
           sd_ctrl_addr_read, sd_ctrl_addr_write, sd_ctrl_data_write
  );

  modport master (
    output req, we0, we1, addr0, addr1, wdata0, wdata1, sd_ctrl_data_read, sd_state,
    input  done, err, busy, rdata, sd_ctrl_re, sd_ctrl_we,
           sd_ctrl_addr_read, sd_ctrl_addr_write, sd_ctrl_data_write
  );
endinterface

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin grant: pointer only matters when both ports request.
module sd_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id    = (&req) ? prio : req[1];
endmodule

// File: rtl/sd_arbiter.sv
// Two-port sector read/write arbiter in front of the SD controller.
// Optional watchdog enabled by defining SD_ARB_TIMEOUT_EN.
module sd_arbiter
  import sd_arb_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  sd_arbiter_if.slave bus
);
  arb_state_t    state;
  logic          prio, gnt_id, gnt_we;
  logic          gnt_valid, sel_id;
  logic          in_flight, ctrl_err, tmo_hit;
  sd_req_t [1:0] port_req;
  sd_req_t       sel;

  assign port_req[0] = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
  assign port_req[1] = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
  assign sel         = port_req[sel_id];
  assign in_flight   = (state == S_ISSUE) || (state == S_RELEASE);
  assign ctrl_err    = (bus.sd_state == SD_ERROR);

  sd_rr_arb2 u_rr (
    .req       (bus.req),
    .prio      (prio),
    .gnt_valid (gnt_valid),
    .gnt_id    (sel_id)
  );

`ifdef SD_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt;
  assign tmo_hit = in_flight && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= S_INIT;
      prio                   <= 1'b0;
      gnt_id                 <= 1'b0;
      gnt_we                 <= 1'b0;
      bus.done               <= '0;
      bus.err                <= 1'b0;
      bus.busy               <= 1'b1;
      bus.rdata              <= '0;
      bus.sd_ctrl_re         <= 1'b0;
      bus.sd_ctrl_we         <= 1'b0;
      bus.sd_ctrl_addr_read  <= '0;
      bus.sd_ctrl_addr_write <= '0;
      bus.sd_ctrl_data_write <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      tmo_cnt                <= '0;
`endif
    end else begin
      bus.done <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      if (in_flight) tmo_cnt <= tmo_cnt + 24'd1;
`endif
      if (state != S_ERROR && (ctrl_err || tmo_hit)) begin
        // Abort: the in-flight requester still gets its completion pulse.
        state          <= S_ERROR;
        bus.err        <= 1'b1;
        bus.busy       <= 1'b1;
        bus.sd_ctrl_re <= 1'b0;
        bus.sd_ctrl_we <= 1'b0;
        if (in_flight) bus.done <= gnt_id ? 2'b10 : 2'b01;
      end else begin
        case (state)
          S_INIT: if (bus.sd_state == SD_IDLE) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
          // No grant while done is out: the finishing port's req is still stale.
          S_IDLE: if (gnt_valid && bus.done == 2'b00) begin
            state    <= S_ISSUE;
            bus.busy <= 1'b1;
            gnt_id   <= sel_id;
            gnt_we   <= sel.we;
`ifdef SD_ARB_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
            if (sel.we) begin
              bus.sd_ctrl_we         <= 1'b1;
              bus.sd_ctrl_addr_write <= sel.addr;
              bus.sd_ctrl_data_write <= sel.wdata;
            end else begin
              bus.sd_ctrl_re         <= 1'b1;
              bus.sd_ctrl_addr_read  <= sel.addr;
            end
          end
          S_ISSUE: begin
            if (!gnt_we && bus.sd_state == SD_READ_END) begin
              bus.rdata      <= bus.sd_ctrl_data_read;
              bus.sd_ctrl_re <= 1'b0;
              state          <= S_RELEASE;
            end else if (gnt_we && bus.sd_state == SD_WRITE_END) begin
              bus.sd_ctrl_we <= 1'b0;
              state          <= S_RELEASE;
            end
          end
          S_RELEASE: if (bus.sd_state == SD_IDLE) begin
            bus.done <= gnt_id ? 2'b10 : 2'b01;
            prio     <= ~gnt_id;
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
          S_ERROR: ;
          default: state <= S_ERROR;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_arbiter.sv
// Randomised scoreboard bench for sd_arbiter with a behavioural SD controller model.
module tb_sd_arbiter;
  import sd_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_arbiter_if bus();
  sd_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit                     we;
    logic [31:0]            addr;
    logic [SECTOR_BITS-1:0] wdata;
  } txn_t;

  int vectors = 0, miscompares = 0;
  bit mon_en = 0, inj_err = 0, stuck = 0, rand_data = 0;
  logic [SECTOR_BITS-1:0] rd_pat = '0;
  txn_t pend0[$], pend1[$];
  int   infl_q[$], gnt_log[$];
  bit   infl_we[$];
  int   n_gnt = 0, n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [SECTOR_BITS-1:0] act,
                          input logic [SECTOR_BITS-1:0] exp);
    int b;
    b = 0;
    vectors++;
    if (act !== exp) begin
      miscompares++;
      for (int i = SECTOR_BITS - 1; i >= 0; i--) if (act[i] !== exp[i]) b = i;
      $display("FAIL %s: got %h.. want %h.. (first bad bit %0d)", name, act[31:0], exp[31:0], b);
    end
  endtask

  function automatic logic [SECTOR_BITS-1:0] rand_sector();
    logic [SECTOR_BITS-1:0] s;
    for (int i = 0; i < SECTOR_BITS / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  // SD controller model: INIT for 20 cycles, then serve level-held re/we.
  int init_cnt, lat;
  always @(posedge clk) begin
    if (reset) begin
      bus.sd_state          <= SD_INIT;
      init_cnt              <= 0;
      lat                   <= 0;
      bus.sd_ctrl_data_read <= '0;
    end else if (inj_err) begin
      bus.sd_state <= SD_ERROR;
    end else begin
      case (bus.sd_state)
        SD_INIT: begin
          init_cnt <= init_cnt + 1;
          if (init_cnt == 19) bus.sd_state <= SD_IDLE;
        end
        SD_IDLE: begin
          lat <= $urandom_range(0, 4);
          if (bus.sd_ctrl_re)      bus.sd_state <= SD_TO_READ;
          else if (bus.sd_ctrl_we) bus.sd_state <= SD_TO_WRITE;
        end
        SD_TO_READ: if (!stuck) begin
          if (lat == 0) begin
            bus.sd_state          <= SD_READ_END;
            bus.sd_ctrl_data_read <= rand_data ? rand_sector() : rd_pat;
          end else lat <= lat - 1;
        end
        SD_READ_END:  if (!bus.sd_ctrl_re) bus.sd_state <= SD_IDLE;
        SD_TO_WRITE:  if (lat == 0) bus.sd_state <= SD_WRITE_END; else lat <= lat - 1;
        SD_WRITE_END: if (!bus.sd_ctrl_we) bus.sd_state <= SD_IDLE;
        default: ;
      endcase
    end
  end

  // Monitor: predicts each grant from the pending requests and last-served
  // port, then matches every done pulse against the granted transaction.
  initial begin
    int p;
    bit w, last_port, due, re_prev, we_prev;
    logic [3:0] sd_prev;
    txn_t t;
    logic [SECTOR_BITS-1:0] exp_rdata;
    last_port = 1; due = 0; re_prev = 0; we_prev = 0; sd_prev = SD_INIT; exp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        pend0.delete(); pend1.delete(); infl_q.delete(); infl_we.delete();
        last_port = 1; due = 0; exp_rdata = '0;
      end else if (mon_en) begin
        if ((bus.sd_ctrl_re && !re_prev) || (bus.sd_ctrl_we && !we_prev)) begin
          chk("ctrl_one_hot", bus.sd_ctrl_re & bus.sd_ctrl_we, 0);
          if (pend0.size() == 0 && pend1.size() == 0) begin
            chk("grant_spurious", 1, 0);
          end else begin
            if (pend0.size() != 0 && pend1.size() != 0) p = last_port ? 0 : 1;
            else p = (pend0.size() != 0) ? 0 : 1;
            t = (p == 1) ? pend1.pop_front() : pend0.pop_front();
            chk("grant_we", bus.sd_ctrl_we, t.we);
            chk("grant_re", bus.sd_ctrl_re, !t.we);
            if (t.we) begin
              chk("grant_addr_w", bus.sd_ctrl_addr_write, t.addr);
              chk_wide("grant_wdata", bus.sd_ctrl_data_write, t.wdata);
            end else chk("grant_addr_r", bus.sd_ctrl_addr_read, t.addr);
            infl_q.push_back(p); infl_we.push_back(t.we); gnt_log.push_back(p); n_gnt++;
          end
        end
        if (sd_prev == SD_READ_END || sd_prev == SD_WRITE_END)
          chk("end_drops_req", bus.sd_ctrl_re | bus.sd_ctrl_we, 0);
        if (due || bus.done != 2'b00) begin
          chk("done_timing", bus.done != 2'b00, due);
          if (bus.done != 2'b00) begin
            if (infl_q.size() == 0) chk("done_spurious", bus.done, 0);
            else begin
              p = infl_q.pop_front(); w = infl_we.pop_front(); n_done++;
              chk("done_port", bus.done, (p == 1) ? 2'b10 : 2'b01);
              if (!w) exp_rdata = bus.sd_ctrl_data_read;
              chk_wide("done_rdata", bus.rdata, exp_rdata);
              last_port = p[0];
            end
          end
        end
        due = (bus.sd_state == SD_IDLE) && (sd_prev == SD_READ_END || sd_prev == SD_WRITE_END);
      end
      sd_prev = bus.sd_state; re_prev = bus.sd_ctrl_re; we_prev = bus.sd_ctrl_we;
    end
  end

  task automatic start_req(input int p, input bit w, input logic [31:0] a,
                           input logic [SECTOR_BITS-1:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    if (p == 0) begin
      bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; pend0.push_back(t); bus.req[0] = 1'b1;
    end else begin
      bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; pend1.push_back(t); bus.req[1] = 1'b1;
    end
  endtask

  task automatic wait_done(input int p, input int bound);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done[p] && n < bound);
    if (!bus.done[p]) begin
      vectors++; miscompares++;
      $display("FAIL done_wait: port %0d got no done within %0d cycles", p, bound);
    end
    bus.req[p] = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 100);
    chk("init_ready", bus.busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_rewe"}, {bus.sd_ctrl_re, bus.sd_ctrl_we}, 0);
    chk({tag, "_addr"}, {bus.sd_ctrl_addr_read, bus.sd_ctrl_addr_write}, 0);
    chk_wide({tag, "_rdata"}, bus.rdata, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, base, nd, first;
    logic [SECTOR_BITS-1:0] wpat;
    reset = 1'b1; bus.req = 2'b00; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;

    // Controller INIT: arbiter must stay busy and quiet until IDLE appears.
    bad = 0;
    for (int i = 0; i < 100 && bus.sd_state != SD_IDLE; i++) begin
      @(negedge clk);
      if (!bus.busy || bus.sd_ctrl_re || bus.sd_ctrl_we) bad++;
    end
    chk("init_quiet", bad, 0);
    chk("init_busy_on_idle", bus.busy, 1);
    @(negedge clk);
    chk("init_busy_falls", bus.busy, 0);
    mon_en = 1;

    // Single read, port 0.
    rd_pat = {512{8'hA5}};
    start_req(0, 1'b0, 32'h100, '0);
    @(negedge clk);
    chk("rd_re_next_cycle", bus.sd_ctrl_re, 1);
    chk("rd_addr", bus.sd_ctrl_addr_read, 32'h100);
    chk("rd_we_low", bus.sd_ctrl_we, 0);
    wait_done(0, 100);
    chk("rd_done", bus.done, 2'b01);
    chk_wide("rd_rdata", bus.rdata, {512{8'hA5}});
    @(negedge clk);
    chk("rd_done_one_cycle", bus.done, 0);

    // Write, port 1, incrementing bytes.
    for (int i = 0; i < SECTOR_BITS / 8; i++) wpat[i*8 +: 8] = 8'(i);
    start_req(1, 1'b1, 32'h2000, wpat);
    @(negedge clk);
    chk("wr_we", bus.sd_ctrl_we, 1);
    chk("wr_re_low", bus.sd_ctrl_re, 0);
    chk("wr_addr", bus.sd_ctrl_addr_write, 32'h2000);
    chk_wide("wr_data", bus.sd_ctrl_data_write, wpat);
    wait_done(1, 100);
    chk("wr_done", bus.done, 2'b10);
    chk_wide("wr_rdata_held", bus.rdata, {512{8'hA5}});

    // Contention: both ports read from the same cycle and re-request at once.
    base = gnt_log.size();
    fork
      begin for (int k = 0; k < 2; k++) begin start_req(0, 1'b0, 32'h10 + k, '0); wait_done(0, 200); end end
      begin for (int k = 0; k < 2; k++) begin start_req(1, 1'b0, 32'h20 + k, '0); wait_done(1, 200); end end
    join
    chk("cont_count", gnt_log.size() - base, 4);
    if (gnt_log.size() - base == 4)
      chk("cont_order", {gnt_log[base][1:0], gnt_log[base+1][1:0], gnt_log[base+2][1:0], gnt_log[base+3][1:0]},
          8'b00_01_00_01);

    // Randomised traffic from both ports.
    rand_data = 1;
    fork
      begin for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_req(0, 1'($urandom_range(0, 1)), $urandom, rand_sector());
        wait_done(0, 300);
      end end
      begin for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start_req(1, 1'($urandom_range(0, 1)), $urandom, rand_sector());
        wait_done(1, 300);
      end end
    join
    repeat (2) @(negedge clk);
    chk("rand_drained", pend0.size() + pend1.size() + infl_q.size(), 0);
    chk("rand_gnt_eq_done", n_done, n_gnt);

    // Controller error during a read: sticky err, single done, requests ignored.
    mon_en = 0; stuck = 1;
    start_req(0, 1'b0, 32'h300, '0);
    repeat (5) @(negedge clk);
    chk("err_pre_re", bus.sd_ctrl_re, 1);
    inj_err = 1;
    @(negedge clk);
    chk("err_not_yet", bus.err, 0);
    @(negedge clk);
    chk("err_set", bus.err, 1);
    chk("err_done", bus.done, 2'b01);
    chk("err_re_cleared", bus.sd_ctrl_re, 0);
    chk("err_busy", bus.busy, 1);
    bus.req[0] = 1'b0;
    start_req(1, 1'b1, 32'h500, '0);
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sd_ctrl_re || bus.sd_ctrl_we || bus.done != 2'b00 || !bus.err) nd++;
    end
    chk("err_ignores_req", nd, 0);

    bus.req = 2'b00; reset = 1'b1; inj_err = 0; stuck = 0;
    @(negedge clk);
    chk_reset_vals("err_reset");
    reset = 1'b0;
    wait_ready();

    // Controller stuck in TO_READ: watchdog fires or the arbiter waits forever.
    stuck = 1;
    start_req(0, 1'b0, 32'h400, '0);
    @(negedge clk);
    chk("stuck_re", bus.sd_ctrl_re, 1);
    first = 0; nd = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (bus.err && first == 0) first = i;
      if (bus.done != 2'b00) nd++;
    end
`ifdef SD_ARB_TIMEOUT_EN
    chk("tmo_cycle", first, 100);
    chk("tmo_done_once", nd, 1);
`else
    chk("no_tmo_err", first, 0);
    chk("no_tmo_done", nd, 0);
    chk("still_waiting", {bus.busy, bus.sd_ctrl_re}, 2'b11);
`endif

    // Reset with a transaction outstanding: everything back to reset values.
    reset = 1'b1; bus.req = 2'b00;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    reset = 1'b0; stuck = 0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sd_arbiter.md
# sd_arbiter

Two-port arbiter and sequencer in front of the SD card controller. Two requesters (port 0: instruction/boot loader path, port 1: data cache refill/writeback path) issue 512-byte sector read or write requests. The block serialises them onto the controller's level-held `re`/`we` interface, tracks the controller state to detect completion, latches read data and reports done or error per port. Fairness is round-robin.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 24'd10_000_000: watchdog limit per transaction, in `clk` cycles. Used only with `SD_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  system clock; same clock as the SD controller FSM.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  2  per-port request, level-held until that port's `done`.
- `we0`, `we1`  in  1  per-port operation: 1 = write, 0 = read. Stable while `req` is high.
- `addr0`, `addr1`  in  32  per-port sector address. Stable while `req` is high.
- `wdata0`, `wdata1`  in  4096  per-port write sector. Stable while `req` is high.
- `done`  out  2  one-cycle completion pulse to the granted port.
- `err`  out  1  sticky error flag. Cleared only by `reset`.
- `busy`  out  1  high whenever state ≠ S_IDLE.
- `rdata`  out  4096  last completed read sector. Held until the next read completes.
- `sd_ctrl_re`, `sd_ctrl_we`  out  1  registered level requests to the controller.
- `sd_ctrl_addr_read`, `sd_ctrl_addr_write`  out  32  registered addresses.
- `sd_ctrl_data_write`  out  4096  registered write sector.
- `sd_ctrl_data_read`  in  4096  controller read data; valid in READ_END.
- `sd_state`  in  4  controller state: INIT=1, IDLE=2, ERROR=3, TO_READ=4, READ_END=5, TO_WRITE=6, WRITE_END=7.

## Operation
- States: S_INIT, S_IDLE, S_ISSUE, S_RELEASE, S_ERROR.
- **S_INIT**:
  - Go to S_IDLE when `sd_state==IDLE`.
  - Go to S_ERROR when `sd_state==ERROR`.
- **S_IDLE**, arbitration:
  - If one `req` bit is set, grant that port.
  - If both are set, grant port `prio` (round-robin pointer, reset value 0).
  - On grant: latch `gnt_id`; load `addr`/`wdata` into the `sd_ctrl_*` registers; set `sd_ctrl_re` (read) or `sd_ctrl_we` (write); go to S_ISSUE.
- **S_ISSUE**:
  - Read: on `sd_state==READ_END`, latch `sd_ctrl_data_read` into `rdata`, clear `sd_ctrl_re`, go to S_RELEASE.
  - Write: on `sd_state==WRITE_END`, clear `sd_ctrl_we`, go to S_RELEASE.
- **S_RELEASE**:
  - On `sd_state==IDLE`, pulse `done[gnt_id]`, set `prio <= ~gnt_id`, go to S_IDLE.
- **S_ERROR**:
  - Entered from any state when `sd_state==ERROR`.
  - On entry: set `err`; clear `sd_ctrl_re`/`sd_ctrl_we`; pulse `done[gnt_id]` once if a transaction was in flight.
  - Terminal until `reset`. Requests are ignored.
- Only one of `sd_ctrl_re`/`sd_ctrl_we` is ever high.
- Requester dropping `req` before `done` is illegal. The transaction still completes and `done` still pulses.

## Timing
- Reset values:
  - state = S_INIT, `prio` = 0.
  - `done`, `err`, `sd_ctrl_re`, `sd_ctrl_we` = 0; `busy` = 1.
  - `rdata`, `sd_ctrl_addr_*`, `sd_ctrl_data_write` = 0.
- Grant: `req` sampled in S_IDLE in cycle N → `sd_ctrl_re/we` high in N+1.
- Completion:
  - READ_END/WRITE_END seen in cycle M → `re/we` low in M+1.
  - `sd_state==IDLE` seen in cycle K → `done` high in K+1, for exactly one cycle, with `rdata` already valid.
- Requester clears `req` on the edge where it samples `done`. Because `done` is registered, the S_IDLE cycle after `done` sees the cleared `req`.
- Minimum gap between back-to-back transactions: 1 S_IDLE cycle.
- Simultaneous requests on both ports: served alternately, never twice in a row to the same port while the other is waiting.
- `reset` in mid-transaction: all outputs return to reset values on the next edge; no `done` pulse. The controller is reset by the same signal.

## Configuration
- `SD_ARB_TIMEOUT_EN` defined:
  - 24-bit counter clears on entry to S_ISSUE and counts in S_ISSUE/S_RELEASE.
  - Reaching `TIMEOUT_CYCLES` enters S_ERROR with the same actions as a controller error.
- Macro undefined: no counter, no timeout path. Waits are unbounded.

## Structure
- Package `sd_arb_pkg`:
  - Controller state encodings (SD_INIT..SD_WRITE_END, 4-bit).
  - Arbiter state enum.
  - `SECTOR_BITS` = 4096.
- Sub-module `sd_rr_arb2`: 2-way round-robin grant logic (`req`, `prio` → `gnt_valid`, `gnt_id`).
- Everything else stays in `sd_arbiter`.

## Test plan
- Init: hold `sd_state`=1 for 20 cycles, then 2 → S_IDLE reached; `busy` falls the next cycle; no `re/we` asserted.
- Single read, port 0, `addr0`=0x100:
  - `sd_ctrl_re` high the cycle after `req`, with `addr_read`=0x100.
  - Model returns READ_END with data 0xA5…A5 → `re` drops.
  - IDLE → `done`=2'b01 for one cycle; `rdata`=0xA5…A5.
- Contention: both ports request reads from the same cycle, each re-requesting after `done` → grants alternate 0,1,0,1; `prio` toggles after each `done`.
- Write, port 1, `addr1`=0x2000, `wdata1`=incrementing bytes → `sd_ctrl_we` high and `data_write` matches; `re` stays 0; `done`=2'b10 after WRITE_END→IDLE.
- Controller `sd_state`=3 during S_ISSUE → `err` sticky high, `done[gnt_id]` pulses once, later `req` ignored until `reset`.
- `SD_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, model stuck in TO_READ → `err` high at cycle 100 after issue; without the macro, still waiting at cycle 1000.
